// File: rtl/servo_pkg.sv
// servo_pkg
//   Shared definitions for the servo pulse generator: move command codes,
//   frame FSM state encoding and default timing (25 MHz clock).
package servo_pkg;

    // Default timing in clocks at 25 MHz
    localparam int unsigned DEF_PERIOD   = 500000;  // 20 ms frame
    localparam int unsigned DEF_MIN_W    = 25000;   // 1.0 ms
    localparam int unsigned DEF_MAX_W    = 50000;   // 2.0 ms
    localparam int unsigned DEF_CENTER_W = 37500;   // 1.5 ms
    localparam int unsigned DEF_STEP     = 250;

    // Move command codes from the angle stage; anything else holds
    localparam logic [3:0] CMD_HOLD = 4'd0;
    localparam logic [3:0] CMD_DEC  = 4'd1;
    localparam logic [3:0] CMD_INC  = 4'd2;
    localparam logic [3:0] CMD_REL  = 4'd5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } state_t;

endpackage

// File: rtl/angle_to_pwm_if.sv
// angle_to_pwm_if
//   Bundles the move command input and the pulse/status outputs of
//   angle_to_pwm.
//   i_Angle   : move command (master -> slave)
//   o_Pwm     : servo pulse
//   o_Frame   : one-cycle strobe on the first cycle of each frame
//   o_At_Min  : position register at minimum width
//   o_At_Max  : position register at maximum width
//   o_Width   : pulse width latched for the current frame
interface angle_to_pwm_if;
    logic [3:0]  i_Angle;
    logic        o_Pwm;
    logic        o_Frame;
    logic        o_At_Min;
    logic        o_At_Max;
    logic [15:0] o_Width;

    modport master (
        output i_Angle,
        input  o_Pwm, o_Frame, o_At_Min, o_At_Max, o_Width
    );

    modport slave (
        input  i_Angle,
        output o_Pwm, o_Frame, o_At_Min, o_At_Max, o_Width
    );
endinterface

// File: rtl/servo_pos_accum.sv
// servo_pos_accum
//   Saturating pulse-width position register.
//   i_Clk       : clock
//   i_Rst_L     : asynchronous active-low reset
//   i_Sample    : update strobe (last cycle of a frame)
//   i_Angle     : move command, decoded only when i_Sample is high
//   o_Pos       : registered position
//   o_Pos_Next  : value o_Pos takes at the next edge
//   o_At_Min    : registered flag, o_Pos == MIN_W
//   o_At_Max    : registered flag, o_Pos == MAX_W
module servo_pos_accum
    import servo_pkg::*;
#(
    parameter int unsigned MIN_W    = DEF_MIN_W,
    parameter int unsigned MAX_W    = DEF_MAX_W,
    parameter int unsigned CENTER_W = DEF_CENTER_W,
    parameter int unsigned STEP     = DEF_STEP
) (
    input  logic        i_Clk,
    input  logic        i_Rst_L,
    input  logic        i_Sample,
    input  logic [3:0]  i_Angle,
    output logic [15:0] o_Pos,
    output logic [15:0] o_Pos_Next,
    output logic        o_At_Min,
    output logic        o_At_Max
);

    localparam logic [15:0] LP_MIN    = 16'(MIN_W);
    localparam logic [15:0] LP_MAX    = 16'(MAX_W);
    localparam logic [15:0] LP_CENTER = 16'(CENTER_W);
    localparam logic [15:0] LP_STEP   = 16'(STEP);
    // Thresholds compared before the add/subtract so nothing wraps
    localparam logic [15:0] LP_DEC_OK = 16'(MIN_W + STEP);
    localparam logic [15:0] LP_INC_OK = 16'(MAX_W - STEP);

    logic [15:0] r_Pos;
    logic [15:0] w_Pos_Next;
    logic        r_At_Min;
    logic        r_At_Max;

    always_comb begin
        w_Pos_Next = r_Pos;
        if (i_Sample) begin
            case (i_Angle)
                CMD_DEC: w_Pos_Next = (r_Pos >= LP_DEC_OK) ? r_Pos - LP_STEP : LP_MIN;
                CMD_INC: w_Pos_Next = (r_Pos <= LP_INC_OK) ? r_Pos + LP_STEP : LP_MAX;
                default: w_Pos_Next = r_Pos;
            endcase
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_Pos    <= LP_CENTER;
            r_At_Min <= 1'b0;
            r_At_Max <= 1'b0;
        end else begin
            r_Pos    <= w_Pos_Next;
            r_At_Min <= (r_Pos == LP_MIN);
            r_At_Max <= (r_Pos == LP_MAX);
        end
    end

    assign o_Pos      = r_Pos;
    assign o_Pos_Next = w_Pos_Next;
    assign o_At_Min   = r_At_Min;
    assign o_At_Max   = r_At_Max;

endmodule

// File: rtl/angle_to_pwm.sv
// angle_to_pwm
//   Servo pulse generator: PERIOD-clock frames, pulse high for the width
//   latched at the start of each frame; width moves by STEP per frame on
//   decrement/increment commands, saturating at MIN_W/MAX_W.
//   i_Clk   : clock, rising edge
//   i_Rst_L : asynchronous active-low reset
//   bus     : i_Angle in; o_Pwm, o_Frame, o_At_Min, o_At_Max, o_Width out
module angle_to_pwm
    import servo_pkg::*;
#(
    parameter int unsigned PERIOD   = DEF_PERIOD,
    parameter int unsigned MIN_W    = DEF_MIN_W,
    parameter int unsigned MAX_W    = DEF_MAX_W,
    parameter int unsigned CENTER_W = DEF_CENTER_W,
    parameter int unsigned STEP     = DEF_STEP
) (
    input  logic           i_Clk,
    input  logic           i_Rst_L,
    angle_to_pwm_if.slave  bus
);

    localparam logic [18:0] LP_LAST   = 19'(PERIOD - 1);
    localparam logic [15:0] LP_CENTER = 16'(CENTER_W);

    state_t      r_State;
    logic [18:0] r_Cnt;
    logic [15:0] r_Width;
    logic        r_Pwm;
    logic        r_Frame;

    logic        w_Sample;
    logic [15:0] w_Pos;
    logic [15:0] w_Pos_Next;
    logic [18:0] w_Width_Last;

    assign w_Sample     = (r_State == ST_LOW) && (r_Cnt == LP_LAST);
    assign w_Width_Last = 19'(r_Width) - 19'd1;

    servo_pos_accum #(
        .MIN_W    (MIN_W),
        .MAX_W    (MAX_W),
        .CENTER_W (CENTER_W),
        .STEP     (STEP)
    ) u_pos (
        .i_Clk      (i_Clk),
        .i_Rst_L    (i_Rst_L),
        .i_Sample   (w_Sample),
        .i_Angle    (bus.i_Angle),
        .o_Pos      (w_Pos),
        .o_Pos_Next (w_Pos_Next),
        .o_At_Min   (bus.o_At_Min),
        .o_At_Max   (bus.o_At_Max)
    );

    // The frame-start latch takes the accumulator's next value, so a command
    // sampled on the last cycle of a frame is already in the following frame.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_State <= ST_IDLE;
            r_Cnt   <= '0;
            r_Width <= LP_CENTER;
            r_Pwm   <= 1'b0;
            r_Frame <= 1'b0;
        end else begin
            r_Frame <= 1'b0;
            case (r_State)
                ST_IDLE: begin
                    r_State <= ST_HIGH;
                    r_Cnt   <= '0;
                    r_Width <= w_Pos;
                    r_Pwm   <= 1'b1;
                    r_Frame <= 1'b1;
                end
                ST_HIGH: begin
                    r_Cnt <= r_Cnt + 19'd1;
                    if (r_Cnt == w_Width_Last) begin
                        r_State <= ST_LOW;
                        r_Pwm   <= 1'b0;
                    end
                end
                ST_LOW: begin
                    if (r_Cnt == LP_LAST) begin
                        r_State <= ST_HIGH;
                        r_Cnt   <= '0;
                        r_Width <= w_Pos_Next;
                        r_Pwm   <= 1'b1;
                        r_Frame <= 1'b1;
                    end else begin
                        r_Cnt <= r_Cnt + 19'd1;
                    end
                end
                default: begin
                    r_State <= ST_IDLE;
                    r_Cnt   <= '0;
                    r_Pwm   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.o_Pwm   = r_Pwm;
    assign bus.o_Frame = r_Frame;
    assign bus.o_Width = r_Width;

endmodule
